// File: rtl/fc_tx_arbiter_if.sv
// Frame-source stream into the FC transmit arbiter (Avalon-ST, readyLatency 0).
// master: the frame source; slave: the arbiter.
interface fc_tx_arbiter_if;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_sop;
    logic        frame_eop;
    logic        frame_ready;

    modport master (
        output frame_data, frame_valid, frame_sop, frame_eop,
        input  frame_ready
    );

    modport slave (
        input  frame_data, frame_valid, frame_sop, frame_eop,
        output frame_ready
    );
endinterface

// File: rtl/fc_tx_arbiter.sv
// FC 8G transmit word scheduler: multiplexes frames, R_RDY credit returns and
// the offline primitive sequence onto the 32-bit TX lane, inserting IDLE fill,
// enforcing the inter-frame gap and aborting underrunning frames with EOFa.
// Optional build macro FC_TX_STATS_EN adds stat_frames / stat_aborts counters.
module fc_tx_arbiter #(
    parameter int MIN_GAP = 6,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 link_active,
    input  logic [31:0]          prim_word,
    fc_tx_arbiter_if.slave       frame,
    input  logic                 rrdy_req,
    input  logic                 tx_ready,
    output logic [31:0]          tx_data,
    output logic [3:0]           tx_datak,
    output logic [CNT_W-1:0]     rrdy_pending,
    output logic                 underrun
`ifdef FC_TX_STATS_EN
    ,
    output logic [31:0]          stat_frames,
    output logic [31:0]          stat_aborts
`endif
);

    localparam logic [31:0] W_IDLE = 32'hBC95_B5B5;
    localparam logic [31:0] W_RRDY = 32'hBC95_4A4A;
    localparam logic [31:0] W_EOFA = 32'hBC95_F5F5;
    localparam logic [3:0]  K_OS   = 4'b1000;
    localparam logic [3:0]  K_DATA = 4'b0000;

    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);

    typedef enum logic [2:0] {
        ST_OFFLINE,
        ST_GAP,
        ST_ARB,
        ST_FRAME,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d, gap_inc;
    logic [CNT_W-1:0]  rrdy_q;
    logic [31:0]       data_p1, data_d, fill_word;
    logic [3:0]        datak_p1, datak_d;
    logic              underrun_p1, underrun_d;
    logic              rrdy_emit;
    logic              frame_ready_c;

    // Pending-credit update: saturates at all-ones, never wraps below zero.
    function automatic logic [CNT_W-1:0] rrdy_next(input logic [CNT_W-1:0] cnt,
                                                   input logic inc,
                                                   input logic dec);
        if (inc && !dec)
            return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
        else if (dec && !inc)
            return (cnt == '0) ? cnt : cnt - 1'b1;
        return cnt;
    endfunction

    // Gap counter step, held at MIN_GAP once the gap is satisfied.
    function automatic logic [GAP_W-1:0] gap_step(input logic [GAP_W-1:0] g);
        return (g >= GAP_MAX) ? GAP_MAX : g + 1'b1;
    endfunction

    assign fill_word = (rrdy_q != '0) ? W_RRDY : W_IDLE;
    assign gap_inc   = gap_step(gap_q);

    // Next word, next state and combinational frame_ready.
    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        data_d        = data_p1;
        datak_d       = datak_p1;
        underrun_d    = underrun_p1;
        rrdy_emit     = 1'b0;
        frame_ready_c = 1'b0;

        // sop words wait for ARB unless a frame is already open (where a
        // repeated sop is just payload) or being drained.
        if (tx_ready) begin
            if (!link_active || state_q == ST_OFFLINE || state_q == ST_GAP)
                frame_ready_c = !frame.frame_sop;
            else
                frame_ready_c = 1'b1;
        end

        if (tx_ready) begin
            underrun_d = 1'b0;
            datak_d    = K_OS;
            if (!link_active) begin
                // Link lost: any open frame is truncated without EOFa.
                data_d  = prim_word;
                state_d = ST_OFFLINE;
                gap_d   = '0;
            end else begin
                case (state_q)
                    ST_OFFLINE: begin
                        data_d  = prim_word;
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                    ST_GAP: begin
                        data_d    = fill_word;
                        rrdy_emit = (rrdy_q != '0);
                        gap_d     = gap_inc;
                        if (gap_inc == GAP_MAX)
                            state_d = ST_ARB;
                    end
                    ST_ARB: begin
                        if (frame.frame_valid && frame.frame_sop) begin
                            data_d  = frame.frame_data;
                            gap_d   = '0;
                            state_d = frame.frame_eop ? ST_GAP : ST_FRAME;
                        end else begin
                            data_d    = fill_word;
                            rrdy_emit = (rrdy_q != '0);
                            gap_d     = gap_inc;
                        end
                    end
                    ST_FRAME: begin
                        if (frame.frame_valid) begin
                            data_d  = frame.frame_data;
                            datak_d = frame.frame_eop ? K_OS : K_DATA;
                            if (frame.frame_eop) begin
                                state_d = ST_GAP;
                                gap_d   = '0;
                            end
                        end else begin
                            data_d     = W_EOFA;
                            underrun_d = 1'b1;
                            state_d    = ST_DRAIN;
                            gap_d      = '0;
                        end
                    end
                    ST_DRAIN: begin
                        // Gap is measured from EOFa, so fill words count here.
                        data_d    = fill_word;
                        rrdy_emit = (rrdy_q != '0);
                        gap_d     = gap_inc;
                        if (frame.frame_valid && frame.frame_eop)
                            state_d = (gap_inc == GAP_MAX) ? ST_ARB : ST_GAP;
                    end
                    default: begin
                        data_d  = prim_word;
                        state_d = ST_OFFLINE;
                        gap_d   = '0;
                    end
                endcase
            end
        end
    end

    // Registered word path and scheduler state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OFFLINE;
            gap_q       <= '0;
            data_p1     <= W_IDLE;
            datak_p1    <= K_OS;
            underrun_p1 <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            data_p1     <= data_d;
            datak_p1    <= datak_d;
            underrun_p1 <= underrun_d;
        end
    end

    // Pending R_RDY count; requests are accepted even while the PHY stalls.
    always_ff @(posedge clk) begin
        if (reset || !link_active)
            rrdy_q <= '0;
        else
            rrdy_q <= rrdy_next(rrdy_q, rrdy_req, rrdy_emit);
    end

    assign frame.frame_ready = frame_ready_c;
    assign tx_data           = data_p1;
    assign tx_datak          = datak_p1;
    assign rrdy_pending      = rrdy_q;
    assign underrun          = underrun_p1;

`ifdef FC_TX_STATS_EN
    logic        frame_done;
    logic        frame_abort;
    logic [31:0] stat_frames_q;
    logic [31:0] stat_aborts_q;

    assign frame_done  = tx_ready && link_active && frame.frame_valid && frame.frame_eop &&
                         ((state_q == ST_FRAME) ||
                          (state_q == ST_ARB && frame.frame_sop));
    assign frame_abort = tx_ready && link_active && (state_q == ST_FRAME) &&
                         !frame.frame_valid;

    // Wrapping counters of completed and aborted frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_frames_q <= '0;
            stat_aborts_q <= '0;
        end else begin
            if (frame_done)
                stat_frames_q <= stat_frames_q + 32'd1;
            if (frame_abort)
                stat_aborts_q <= stat_aborts_q + 32'd1;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_aborts = stat_aborts_q;
`endif

endmodule

// File: tb/tb_fc_tx_arbiter.sv
// Randomized scoreboard bench for fc_tx_arbiter: a behavioural model predicts
// every TX word and frame_ready; a monitor compares on the falling edge.
module tb_fc_tx_arbiter;

    localparam int MIN_GAP = 6;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] W_IDLE = 32'hBC95_B5B5;
    localparam logic [31:0] W_RRDY = 32'hBC95_4A4A;
    localparam logic [31:0] W_EOFA = 32'hBC95_F5F5;

    logic             clk = 1'b0;
    logic             reset;
    logic             link_active;
    logic [31:0]      prim_word;
    logic             rrdy_req;
    logic             tx_ready;
    logic [31:0]      tx_data;
    logic [3:0]       tx_datak;
    logic [CNT_W-1:0] rrdy_pending;
    logic             underrun;
`ifdef FC_TX_STATS_EN
    logic [31:0]      stat_frames;
    logic [31:0]      stat_aborts;
`endif

    fc_tx_arbiter_if fif();

    fc_tx_arbiter #(.MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .link_active  (link_active),
        .prim_word    (prim_word),
        .frame        (fif),
        .rrdy_req     (rrdy_req),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_datak     (tx_datak),
        .rrdy_pending (rrdy_pending),
        .underrun     (underrun)
`ifdef FC_TX_STATS_EN
        ,
        .stat_frames  (stat_frames),
        .stat_aborts  (stat_aborts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ready;
        logic [31:0] data;
        logic [3:0]  k;
        int          pend;
        bit          und;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        bit          sop;
        bit          eop;
    } beat_t;

    exp_t  sbq[$];
    beat_t src[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: link status, frame/drain flags, fill words since the
    // last EOF/EOFa (unbounded), and the pending credit count.
    bit          m_online, m_in_frame, m_drop, m_und;
    int          m_fill, m_pend, m_frames, m_aborts;
    logic [31:0] m_data;
    logic [3:0]  m_k;
    int          und_seen = 0;

    // Stimulus shaping state (stimulus process only).
    int stall_left = 0;
    int down_left  = 8;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_online   = 0;
        m_in_frame = 0;
        m_drop     = 0;
        m_und      = 0;
        m_fill     = 0;
        m_pend     = 0;
        m_data     = W_IDLE;
        m_k        = 4'b1000;
    endtask

    // One cycle of the model using the inputs currently driven.
    task automatic model_step(output bit rdy);
        bit la, fv, sop, eop;
        int dec;
        la  = link_active;
        fv  = fif.frame_valid;
        sop = fif.frame_sop;
        eop = fif.frame_eop;
        dec = 0;
        if (!tx_ready)
            rdy = 0;
        else if (!la || !m_online)
            rdy = !sop;
        else if (m_in_frame || m_drop || m_fill >= MIN_GAP)
            rdy = 1;
        else
            rdy = !sop;

        if (tx_ready) begin
            m_und = 0;
            m_k   = 4'b1000;
            if (!la) begin
                m_data     = prim_word;
                m_online   = 0;
                m_in_frame = 0;
                m_drop     = 0;
                m_fill     = 0;
            end else if (!m_online) begin
                m_data   = prim_word;
                m_online = 1;
                m_fill   = 0;
            end else if (m_in_frame) begin
                if (fv) begin
                    m_data = fif.frame_data;
                    m_k    = eop ? 4'b1000 : 4'b0000;
                    if (eop) begin
                        m_in_frame = 0;
                        m_fill     = 0;
                        m_frames++;
                    end
                end else begin
                    m_data     = W_EOFA;
                    m_und      = 1;
                    m_in_frame = 0;
                    m_drop     = 1;
                    m_fill     = 0;
                    m_aborts++;
                end
            end else if (!m_drop && m_fill >= MIN_GAP && fv && sop) begin
                m_data = fif.frame_data;
                m_fill = 0;
                if (eop) m_frames++;
                else     m_in_frame = 1;
            end else begin
                m_data = (m_pend > 0) ? W_RRDY : W_IDLE;
                if (m_pend > 0) dec = 1;
                m_fill++;
                if (m_drop && fv && eop) m_drop = 0;
            end
        end

        if (!la)
            m_pend = 0;
        else begin
            m_pend = m_pend + (rrdy_req ? 1 : 0) - dec;
            if (m_pend > CNT_MAX) m_pend = CNT_MAX;
            if (m_pend < 0)       m_pend = 0;
        end
    endtask

    task automatic gen_frame();
        beat_t b;
        int n;
        if ($urandom_range(0, 9) == 0) begin
            b.d = $urandom; b.sop = 0; b.eop = 0;
            src.push_back(b);
        end
        b.d = 32'hBC95_5656 ^ {24'h0, 8'($urandom)}; b.sop = 1; b.eop = 0;
        src.push_back(b);
        n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) begin
            b.d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            b.sop = ($urandom_range(0, 29) == 0);
            b.eop = 0;
            src.push_back(b);
        end
        b.d = 32'hBC95_7575; b.sop = 0; b.eop = 1;
        src.push_back(b);
    endtask

    task automatic run_cycle(input bit do_rst);
        exp_t e;
        bit   rdy;
        reset = do_rst;
        if (src.size() == 0) gen_frame();
        fif.frame_data = src[0].d;
        fif.frame_sop  = src[0].sop;
        fif.frame_eop  = src[0].eop;
        if (do_rst)
            fif.frame_valid = 0;
        else if (src[0].sop)
            fif.frame_valid = ($urandom_range(0, 99) < 70);
        else
            fif.frame_valid = ($urandom_range(0, 99) < 96);
        rrdy_req = ($urandom_range(0, 99) < 18);
        if (stall_left > 0) begin
            tx_ready = 0;
            stall_left--;
        end else if ($urandom_range(0, 199) == 0) begin
            tx_ready   = 0;
            stall_left = 4;
        end else begin
            tx_ready = ($urandom_range(0, 99) < 90);
        end
        if (down_left > 0) begin
            link_active = 0;
            down_left--;
        end else if ($urandom_range(0, 399) == 0) begin
            link_active = 0;
            down_left   = $urandom_range(2, 10);
            case ($urandom_range(0, 3))
                0: prim_word = 32'hBC55_B5B5;
                1: prim_word = 32'hBC35_B5B5;
                2: prim_word = 32'hBC49_B5B5;
                default: prim_word = 32'hBC35_4949;
            endcase
        end else begin
            link_active = 1;
        end
        if (do_rst) begin
            model_reset();
        end else begin
            e.data = m_data;
            e.k    = m_k;
            e.pend = m_pend;
            e.und  = m_und;
            model_step(rdy);
            e.ready = rdy;
            sbq.push_back(e);
            if (fif.frame_valid && rdy) void'(src.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each cycle's DUT view against the queued prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("frame_ready", {31'h0, fif.frame_ready}, {31'h0, e.ready});
            check("tx_data", tx_data, e.data);
            check("tx_datak", {28'h0, tx_datak}, {28'h0, e.k});
            check("rrdy_pending", {{(32-CNT_W){1'b0}}, rrdy_pending}, 32'(e.pend));
            check("underrun", {31'h0, underrun}, {31'h0, e.und});
            if (underrun === 1'b1 && tx_ready === 1'b1) und_seen++;
        end
    end

    initial begin
        reset           = 1;
        link_active     = 0;
        prim_word       = 32'hBC55_B5B5;
        rrdy_req        = 0;
        tx_ready        = 1;
        fif.frame_data  = '0;
        fif.frame_valid = 0;
        fif.frame_sop   = 0;
        fif.frame_eop   = 0;
        m_frames        = 0;
        m_aborts        = 0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) run_cycle(1);
        for (int i = 0; i < 3000; i++) run_cycle(0);
        for (int i = 0; i < 2; i++) run_cycle(1);
        m_frames = 0;
        m_aborts = 0;
        for (int i = 0; i < 3000; i++) run_cycle(0);
        tx_ready = 0;
        rrdy_req = 0;
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        check("underrun_pulses_nonzero", {31'h0, und_seen > 0}, 32'd1);
`ifdef FC_TX_STATS_EN
        check("stat_frames", stat_frames, 32'(m_frames));
        check("stat_aborts", stat_aborts, 32'(m_aborts));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_tx_arbiter.md
Name: fc_tx_arbiter

Overview:
- Transmit-side scheduler for the FC 8G transceiver word stream.
- Shares the 32-bit TX lane between three sources:
  - the frame source (Avalon-ST, SOF…EOF words);
  - the R_RDY credit-return requester;
  - the port state machine's offline primitive sequence (NOS/OLS/LR/LRR).
- Inserts IDLE fill, enforces the FC inter-frame gap, and aborts underrunning frames with EOFa.
- Sits between the frame/credit logic and the PHY tx_parallel_data/tx_datak input.

Parameters:
- MIN_GAP, 6: minimum primitive-signal words (IDLE or R_RDY) between an EOF and the next SOF.
- CNT_W, 8: width of the pending-R_RDY counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  core clock; one TX word per cycle when tx_ready is high.
- reset  in  1  synchronous, active-high reset.
- link_active  in  1  high when the port state machine is in STATE_AC.
- prim_word  in  32  offline ordered set, sent continuously while link_active=0.
- frame_data  in  32  frame word; the SOF word is on sop and the EOF word is on eop.
- frame_valid  in  1  Avalon-ST valid.
- frame_sop  in  1  start of packet.
- frame_eop  in  1  end of packet.
- frame_ready  out  1  Avalon-ST ready, readyLatency 0.
- rrdy_req  in  1  one-cycle pulse requesting one R_RDY.
- tx_ready  in  1  PHY accepts the word this cycle; when low, all state and outputs hold.
- tx_data  out  32  word to the PHY, big-endian byte order (K28.5 in [31:24]).
- tx_datak  out  4  K flags; 4'b1000 for ordered sets, 4'b0000 for frame payload.
- rrdy_pending  out  CNT_W  current pending-R_RDY count.
- underrun  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Word constants:
  - IDLE = 0xBC95B5B5
  - R_RDY = 0xBC954A4A
  - EOFa = 0xBC95F5F5
- Outputs are registered; an accepted frame word appears on tx_data one cycle after its frame_ready&&frame_valid beat.
- Reset values: tx_data=IDLE, tx_datak=4'b1000, frame_ready=0, rrdy_pending=0, underrun=0, state=OFFLINE, gap counter=0.
- Every state transition and counter update is qualified by tx_ready=1. Exceptions:
  - rrdy_req increments the counter on any cycle.
  - Reset acts on any cycle.
- frame_ready is combinational from state, tx_ready, link_active, frame_sop and the gap counter.
- R_RDY counter:
  - +1 on rrdy_req; −1 when an R_RDY is emitted; both in the same cycle leaves it unchanged.
  - Saturates at maximum and does not go below 0.
  - Cleared while link_active=0.
- States:
  - OFFLINE:
    - Emit prim_word with datak 1000.
    - frame_ready=1 only to discard words that are not sop (flush stale tails); sop words are held.
    - On link_active rising, go to GAP with the gap counter at 0.
  - GAP (gap counter < MIN_GAP):
    - Emit R_RDY if pending>0, else IDLE.
    - The gap counter increments each emitted word.
    - frame_ready=1 only for non-sop words (discarded as orphan payload).
    - When the counter reaches MIN_GAP, go to ARB.
  - ARB:
    - If frame_valid&&frame_sop: frame_ready=1, emit frame_data with datak 1000, go to FRAME. Frames take priority over pending R_RDY.
    - Else emit R_RDY if pending, else IDLE. Non-sop words are discarded.
  - FRAME:
    - frame_ready=1. Emit each word with datak 0000, except the eop word, which gets datak 1000.
    - On eop, go to GAP with the gap counter reset to 0.
    - A second sop inside a frame is treated as payload.
  - FRAME underrun (frame_valid=0 in FRAME with tx_ready=1):
    - Emit EOFa and pulse underrun.
    - Go to DRAIN.
  - DRAIN:
    - frame_ready=1; words are discarded while IDLE/R_RDY fill is emitted.
    - The gap counter counts emitted fill words.
    - On the eop beat, go to GAP, keeping the count so the gap is measured from EOFa.
    - A discarded sop in DRAIN starts nothing; the block keeps draining until eop.
  - link_active falling in any state:
    - Next word is prim_word; go to OFFLINE.
    - A frame in progress is truncated without EOFa (the link is down).
    - The remaining beats of that frame are discarded in OFFLINE.
- Reset mid-frame returns to OFFLINE with reset values; frame beats still queued upstream are discarded as non-sop words.

Optional Feature:
- FC_TX_STATS_EN defined:
  - Adds outputs stat_frames[31:0] (count of EOF words emitted, excluding EOFa) and stat_aborts[31:0] (EOFa count).
  - Both counters wrap, reset to 0, and advance only with tx_ready.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Link up, no traffic: link_active 0→1 → six IDLE words, then continuous IDLE; before link up, tx_data=prim_word (e.g. 0xBC55B5B5) with datak 1000.
- Frame of SOFi3, 10×0x00000000, EOFt words → tx shows SOFi3/1000, ten zero words/0000, EOFt/1000, each one cycle after its accept; the next frame's SOF appears no earlier than 6 words after EOFt.
- Back-to-back frames with 3 rrdy_req pulses during the first frame → the gap emits R_RDY×3 then IDLE×3, followed by the second SOF; rrdy_pending goes 3→0.
- Underrun: frame_valid drops after 4 payload words → next word EOFa (0xBC95F5F5), underrun pulses once, remaining beats up to eop are dropped, and six fill words follow EOFa.
- tx_ready low for 5 cycles mid-frame → tx_data frozen, frame_ready=0, no words lost or duplicated; simultaneous rrdy_req and R_RDY emission leaves the count unchanged.
- link_active drops mid-frame → the next word is prim_word, rrdy_pending=0, the frame tail is discarded; with FC_TX_STATS_EN, stat_frames is not incremented.
